// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply
// and restoring divide, with a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  // Iterative job: divide flag and the operand that stays fixed across iterations
  // (multiplicand for MULU, divisor for DIVU).
  typedef struct packed {
    logic             div;
    logic [WIDTH-1:0] opnd;
  } job_t;

  state_t             state, state_n;
  job_t               job;
  logic [2*WIDTH:0]   acc, step;
  logic [CNT_W-1:0]   cnt;
  logic               accept, iterative, last;

  logic [WIDTH-1:0]   sum, dif, sc_res;
  logic               sc_ovf, slt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_dif;
  logic [2*WIDTH:0]   div_sh;

  assign accept    = (state == IDLE) && start_i;
  assign iterative = (ctrl_i == OP_MULU) || (ctrl_i == OP_DIVU);
  assign last      = (state == RUN) && (cnt == CNT_W'(1));
  assign busy_o    = (state == RUN);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && iterative) state_n = RUN;
      RUN:     if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sum    = src1_i + src2_i;
    dif    = src1_i - src2_i;
    slt    = $signed(src1_i) < $signed(src2_i);
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ctrl_i)
      OP_AND: sc_res = src1_i & src2_i;
      OP_OR:  sc_res = src1_i | src2_i;
      OP_NOR: sc_res = ~(src1_i | src2_i);
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, slt};
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (dif[WIDTH-1] != src1_i[WIDTH-1]);
      end
      default: sc_res = '0;
    endcase
  end

  // MULU: acc = {carry, hi, multiplier}, add-then-shift-right.
  // DIVU: acc = {partial remainder, dividend/quotient}, shift-left-then-trial-subtract.
  // Both leave {hi, lo} in acc[2W-1:0] after WIDTH steps.
  always_comb begin
    mul_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, job.opnd} : '0);
    div_sh  = {acc[2*WIDTH-1:0], 1'b0};
    div_dif = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, job.opnd};
    if (job.div)
      step = div_dif[WIDTH+1] ? div_sh : {div_dif[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
    else
      step = {1'b0, mul_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      job        <= '0;
      acc        <= '0;
      cnt        <= '0;
      result_o   <= '0;
      hi_o       <= '0;
      zero_o     <= 1'b0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        if (iterative) begin
          job <= '{div: (ctrl_i == OP_DIVU), opnd: (ctrl_i == OP_DIVU) ? src2_i : src1_i};
          acc <= {{(WIDTH+1){1'b0}}, (ctrl_i == OP_DIVU) ? src1_i : src2_i};
          cnt <= CNT_INIT;
        end else begin
          result_o   <= sc_res;
          hi_o       <= '0;
          zero_o     <= (sc_res == '0);
          overflow_o <= sc_ovf;
          done_o     <= 1'b1;
        end
      end else if (state == RUN) begin
        acc <= step;
        cnt <= cnt - 1'b1;
        if (last) begin
          result_o   <= step[WIDTH-1:0];
          hi_o       <= step[2*WIDTH-1:WIDTH];
          zero_o     <= (step[WIDTH-1:0] == '0);
          overflow_o <= 1'b0;
          done_o     <= 1'b1;
        end
      end
    end
  end

endmodule
